// File: rtl/palette_pkg.sv
// Shared types and the fixed 16-entry sprite palette for the palette round-robin arbiter.
package palette_pkg;

  localparam int DEF_IDX_W           = 4;
  localparam int DEF_COLOR_W         = 4;
  localparam int DEF_TRANSPARENT_IDX = 0;
  localparam int PAL_DEPTH           = 16;
  localparam int PAL_IDX_W           = 4;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

  // Entry 0 is the colour key; it still carries a real colour for debug visibility.
  localparam rgb_t PALETTE [0:PAL_DEPTH-1] = '{
    '{4'hA, 4'hE, 4'hA},
    '{4'h0, 4'h0, 4'h0},
    '{4'hF, 4'hF, 4'hF},
    '{4'hF, 4'h7, 4'h6},
    '{4'h0, 4'h5, 4'h0},
    '{4'h0, 4'h5, 4'h0},
    '{4'hA, 4'hE, 4'hA},
    '{4'hA, 4'hE, 4'hA},
    '{4'hA, 4'hE, 4'hA},
    '{4'hA, 4'hE, 4'hA},
    '{4'hA, 4'hE, 4'hA},
    '{4'hA, 4'hE, 4'hA},
    '{4'h0, 4'h0, 4'h0},
    '{4'h0, 4'h5, 4'h0},
    '{4'hA, 4'hE, 4'hA},
    '{4'hA, 4'hE, 4'hA}
  };

  function automatic rgb_t pal_lookup(input logic [PAL_IDX_W-1:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any_req
);

  int   j;
  logic found;

  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
    any_req = found;
  end

endmodule

// File: rtl/palette_rr_arbiter.sv
// Round-robin shared palette lookup with a registered, back-pressurable response stage.
// Optional duck-hit flash enabled by defining PALETTE_HIT_FLASH_EN (adds flash_mask input).
module palette_rr_arbiter
  import palette_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int IDX_W           = DEF_IDX_W,
  parameter int COLOR_W         = DEF_COLOR_W,
  parameter int TRANSPARENT_IDX = DEF_TRANSPARENT_IDX,
  parameter int ID_W            = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_index,
  output logic [NUM_REQ-1:0]       req_ready,
`ifdef PALETTE_HIT_FLASH_EN
  input  logic [NUM_REQ-1:0]       flash_mask,
`endif
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [COLOR_W-1:0]       rsp_red,
  output logic [COLOR_W-1:0]       rsp_green,
  output logic [COLOR_W-1:0]       rsp_blue,
  output logic                     rsp_transparent,
  input  logic                     rsp_ready
);

  logic [IDX_W-1:0]   idx_arr [NUM_REQ];
  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

  logic               load_en;
  logic               xfer;
  logic [IDX_W-1:0]   sel_index;
  logic               sel_transparent;
  logic               sel_flash;
  rgb_t               sel_rgb;

  logic [ID_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic               rsp_valid_reg;
  logic [ID_W-1:0]    rsp_id_reg;
  logic [COLOR_W-1:0] red_reg, green_reg, blue_reg;
  logic [COLOR_W-1:0] red_next, green_next, blue_next;
  logic               transp_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign idx_arr[gi] = req_index[gi*IDX_W +: IDX_W];
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_reg),
    .grant   (pick_grant),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  // The output register only accepts new data when empty or being drained this cycle.
  assign load_en   = !rsp_valid_reg || rsp_ready;
  assign xfer      = load_en && pick_any;
  assign req_ready = xfer ? pick_grant : '0;

  assign sel_index       = idx_arr[pick_idx];
  assign sel_transparent = (sel_index == IDX_W'(TRANSPARENT_IDX));
  assign sel_rgb         = pal_lookup(PAL_IDX_W'(sel_index));

`ifdef PALETTE_HIT_FLASH_EN
  assign sel_flash = flash_mask[pick_idx] && !sel_transparent;
`else
  assign sel_flash = 1'b0;
`endif

  always_comb begin
    red_next   = COLOR_W'(sel_rgb.r);
    green_next = COLOR_W'(sel_rgb.g);
    blue_next  = COLOR_W'(sel_rgb.b);
    if (sel_flash) begin
      red_next   = '1;
      green_next = '1;
      blue_next  = '1;
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (xfer) begin
      if (pick_idx == ID_W'(NUM_REQ - 1)) begin
        rr_ptr_next = '0;
      end else begin
        rr_ptr_next = pick_idx + ID_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      red_reg       <= '0;
      green_reg     <= '0;
      blue_reg      <= '0;
      transp_reg    <= 1'b0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      if (load_en) begin
        rsp_valid_reg <= pick_any;
      end
      if (xfer) begin
        rsp_id_reg <= pick_idx;
        red_reg    <= red_next;
        green_reg  <= green_next;
        blue_reg   <= blue_next;
        transp_reg <= sel_transparent;
      end
    end
  end

  assign rsp_valid       = rsp_valid_reg;
  assign rsp_id          = rsp_id_reg;
  assign rsp_red         = red_reg;
  assign rsp_green       = green_reg;
  assign rsp_blue        = blue_reg;
  assign rsp_transparent = transp_reg;

endmodule
